// File: rtl/branch_resolve_queue_pkg.sv
// Shared layout for the branch resolve queue.
// The gshare predictor uses the same HISTORY_LEN.
package branch_resolve_queue_pkg;

    localparam int PC_WIDTH        = 16;
    localparam int BRQ_HISTORY_LEN = 8;
    localparam int BRQ_DEPTH       = 8;

    // One entry is packed as {pc, history, pred}.
    function automatic int brq_entry_w(input int hist_len);
        return PC_WIDTH + hist_len + 1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_storage.sv
// Entry register file for the branch resolve queue.
// It has one synchronous write port and one combinational read port.
module brq_storage #(
    parameter int DEPTH   = 8,
    parameter int PTR_LEN = 3,
    parameter int W       = 25
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_LEN-1:0] waddr_i,
    input  logic [W-1:0]       wdata_i,
    input  logic [PTR_LEN-1:0] raddr_i,
    output logic [W-1:0]       rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches.
// Resolving a branch drives the predictor's update port one cycle later.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int HISTORY_LEN = BRQ_HISTORY_LEN,
    parameter int DEPTH       = BRQ_DEPTH,
    parameter int PTR_LEN     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [PC_WIDTH-1:0]    push_pc,
    input  logic [HISTORY_LEN-1:0] push_history,
    input  logic                   push_prediction,
    output logic                   push_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_outcome,
    output logic                   resolve_ready,
    output logic                   update_write_enabled,
    output logic [PC_WIDTH-1:0]    update_pc,
    output logic [HISTORY_LEN-1:0] update_history,
    output logic                   update_outcome,
    output logic                   mispredict,
    output logic [PTR_LEN:0]       count
);

    localparam int               EW     = brq_entry_w(HISTORY_LEN);
    localparam logic [PTR_LEN:0] FULL   = (PTR_LEN+1)'(DEPTH);
    localparam logic [PTR_LEN:0] C_ONE  = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN-1:0] P_ONE = PTR_LEN'(1);

    logic [PTR_LEN-1:0]     head_q, head_d;
    logic [PTR_LEN-1:0]     tail_q, tail_d;
    logic [PTR_LEN:0]       count_q, count_d;
    logic                   upd_we_q;
    logic                   mis_q;
    logic [PC_WIDTH-1:0]    upd_pc_q;
    logic [HISTORY_LEN-1:0] upd_hist_q;
    logic                   upd_out_q;

    logic                   push_fire;
    logic                   pop_fire;
    logic                   flush;
    logic [EW-1:0]          wdata;
    logic [EW-1:0]          rdata;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [HISTORY_LEN-1:0] head_hist;
    logic                   head_pred;

    assign wdata = {push_pc, push_history, push_prediction};
    assign {head_pc, head_hist, head_pred} = rdata;

    assign push_ready    = (count_q != FULL);
    assign resolve_ready = (count_q != '0);
    assign push_fire     = push_valid && push_ready;
    assign pop_fire      = resolve_valid && resolve_ready;
    assign flush         = pop_fire && (head_pred != resolve_outcome);

    brq_storage #(
        .DEPTH   (DEPTH),
        .PTR_LEN (PTR_LEN),
        .W       (EW)
    ) u_storage (
        .clk     (clk),
        .we_i    (push_fire && !flush),
        .waddr_i (tail_q),
        .wdata_i (wdata),
        .raddr_i (head_q),
        .rdata_o (rdata)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Younger entries are wrong-path; the same-cycle push is dropped too.
            head_d  = head_q + P_ONE;
            tail_d  = head_q + P_ONE;
            count_d = '0;
        end else begin
            if (push_fire) tail_d = tail_q + P_ONE;
            if (pop_fire)  head_d = head_q + P_ONE;
            unique case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + C_ONE;
                2'b01:   count_d = count_q - C_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            upd_we_q   <= 1'b0;
            mis_q      <= 1'b0;
            upd_pc_q   <= '0;
            upd_hist_q <= '0;
            upd_out_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            upd_we_q <= pop_fire;
            mis_q    <= flush;
            if (pop_fire) begin
                upd_pc_q   <= head_pc;
                upd_hist_q <= head_hist;
                upd_out_q  <= resolve_outcome;
            end
        end
    end

    assign update_write_enabled = upd_we_q;
    assign mispredict           = mis_q;
    assign update_pc            = upd_pc_q;
    assign update_history       = upd_hist_q;
    assign update_outcome       = upd_out_q;
    assign count                = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue.
// Compares the DUT against a queue-based reference model.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [15:0] push_pc;
    logic [7:0]  push_history;
    logic        push_prediction;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_outcome;
    logic        resolve_ready;
    logic        update_write_enabled;
    logic [15:0] update_pc;
    logic [7:0]  update_history;
    logic        update_outcome;
    logic        mispredict;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  h;
        logic        p;
    } ent_t;

    ent_t        mq[$];
    logic        m_we, m_mis, m_out;
    logic [15:0] m_pc;
    logic [7:0]  m_h;

    always #5 clk = ~clk;

    branch_resolve_queue dut (
        .clk                  (clk),
        .reset                (reset),
        .push_valid           (push_valid),
        .push_pc              (push_pc),
        .push_history         (push_history),
        .push_prediction      (push_prediction),
        .push_ready           (push_ready),
        .resolve_valid        (resolve_valid),
        .resolve_outcome      (resolve_outcome),
        .resolve_ready        (resolve_ready),
        .update_write_enabled (update_write_enabled),
        .update_pc            (update_pc),
        .update_history       (update_history),
        .update_outcome       (update_outcome),
        .mispredict           (mispredict),
        .count                (count)
    );

    // Drive one cycle, advance the model on the edge, settle 1 time unit.
    task automatic step(input logic pv, input logic [15:0] pc,
                        input logic [7:0] h, input logic pr,
                        input logic rv, input logic ro,
                        input logic rst);
        bit   do_push, do_pop;
        ent_t e;
        reset           = rst;
        push_valid      = pv;
        push_pc         = pc;
        push_history    = h;
        push_prediction = pr;
        resolve_valid   = rv;
        resolve_outcome = ro;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_we = 0; m_mis = 0; m_out = 0; m_pc = '0; m_h = '0;
        end else begin
            do_push = pv && (mq.size() < 8);
            do_pop  = rv && (mq.size() > 0);
            m_we  = 0;
            m_mis = 0;
            if (do_pop) begin
                e     = mq.pop_front();
                m_we  = 1;
                m_pc  = e.pc;
                m_h   = e.h;
                m_out = ro;
                m_mis = (e.p != ro);
            end
            if (m_mis) mq.delete();
            else if (do_push) mq.push_back('{pc, h, pr});
        end
        #1;
        reset         = 1'b0;
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, '0, '0, 0, 0, 0, 1);
        n_cmp += 6;
        if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
        if (resolve_ready !== 1'b0) begin n_bad++; $display("FAIL reset_resolve_ready got %b want 0", resolve_ready); end
        if (update_write_enabled !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", update_write_enabled); end
        if (mispredict !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b want 0", mispredict); end
        if ({update_pc, update_history, update_outcome} !== 25'd0) begin
            n_bad++; $display("FAIL reset_update got %0h want 0", {update_pc, update_history, update_outcome});
        end
    endtask

    task automatic test_basic();
        step(1, 16'h0104, 8'h5A, 1, 0, 0, 0);
        n_cmp++;
        if (update_write_enabled !== 1'b0) begin n_bad++; $display("FAIL basic_no_early_we got %b want 0", update_write_enabled); end
        step(0, '0, '0, 0, 1, 1, 0);
        n_cmp += 6;
        if (update_write_enabled !== 1'b1) begin n_bad++; $display("FAIL basic_we got %b want 1", update_write_enabled); end
        if (update_pc !== 16'h0104) begin n_bad++; $display("FAIL basic_pc got %h want 0104", update_pc); end
        if (update_history !== 8'h5A) begin n_bad++; $display("FAIL basic_hist got %h want 5a", update_history); end
        if (update_outcome !== 1'b1) begin n_bad++; $display("FAIL basic_out got %b want 1", update_outcome); end
        if (mispredict !== 1'b0) begin n_bad++; $display("FAIL basic_mis got %b want 0", mispredict); end
        if (count !== 4'd0) begin n_bad++; $display("FAIL basic_count got %0d want 0", count); end
        idle();
        n_cmp += 2;
        if (update_write_enabled !== 1'b0) begin n_bad++; $display("FAIL basic_we_drop got %b want 0", update_write_enabled); end
        if (update_pc !== 16'h0104) begin n_bad++; $display("FAIL basic_pc_hold got %h want 0104", update_pc); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 8'(i * 3), i[0], 0, 0, 0);
        n_cmp += 2;
        if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count); end
        if (push_ready !== 1'b0) begin n_bad++; $display("FAIL fill_push_ready got %b want 0", push_ready); end
        step(1, 16'hDEAD, 8'hEE, 0, 0, 0, 0);
        n_cmp++;
        if (count !== 4'd8) begin n_bad++; $display("FAIL fill_ninth got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            step(0, '0, '0, 0, 1, i[0], 0);
            n_cmp += 3;
            if (update_pc !== 16'h1000 + 16'(i)) begin n_bad++; $display("FAIL wrap_pc%0d got %h want %h", i, update_pc, 16'h1000 + 16'(i)); end
            if (update_history !== 8'(i * 3)) begin n_bad++; $display("FAIL wrap_hist%0d got %h want %h", i, update_history, 8'(i * 3)); end
            if (mispredict !== 1'b0) begin n_bad++; $display("FAIL wrap_mis%0d got %b want 0", i, mispredict); end
        end
        n_cmp++;
        if (resolve_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_empty got %b want 0", resolve_ready); end
    endtask

    task automatic test_mispredict_flush();
        step(1, 16'h2000, 8'h11, 0, 0, 0, 0);
        step(1, 16'h2004, 8'h22, 1, 0, 0, 0);
        step(1, 16'h2008, 8'h33, 1, 0, 0, 0);
        step(1, 16'h200C, 8'h44, 1, 1, 1, 0);
        n_cmp += 5;
        if (mispredict !== 1'b1) begin n_bad++; $display("FAIL flush_mis got %b want 1", mispredict); end
        if (update_pc !== 16'h2000) begin n_bad++; $display("FAIL flush_pc got %h want 2000", update_pc); end
        if (count !== 4'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
        if (resolve_ready !== 1'b0) begin n_bad++; $display("FAIL flush_resolve_ready got %b want 0", resolve_ready); end
        if (update_write_enabled !== 1'b1) begin n_bad++; $display("FAIL flush_we got %b want 1", update_write_enabled); end
        idle();
        n_cmp++;
        if (mispredict !== 1'b0) begin n_bad++; $display("FAIL flush_mis_pulse got %b want 0", mispredict); end
        step(1, 16'h3000, 8'h99, 0, 0, 0, 0);
        step(0, '0, '0, 0, 1, 0, 0);
        n_cmp += 2;
        if (update_pc !== 16'h3000) begin n_bad++; $display("FAIL flush_after_pc got %h want 3000", update_pc); end
        if (count !== 4'd0) begin n_bad++; $display("FAIL flush_after_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pc;
        for (int i = 0; i < 4; i++) step(1, 16'h4000 + 16'(i), 8'(i), i[1], 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            exp_pc = 16'h4000 + 16'(i);
            step(1, 16'h4004 + 16'(i), 8'(i + 4), ~i[0], 1, mq[0].p, 0);
            n_cmp += 4;
            if (count !== 4'd4) begin n_bad++; $display("FAIL b2b_count%0d got %0d want 4", i, count); end
            if (update_write_enabled !== 1'b1) begin n_bad++; $display("FAIL b2b_we%0d got %b want 1", i, update_write_enabled); end
            if (update_pc !== exp_pc) begin n_bad++; $display("FAIL b2b_pc%0d got %h want %h", i, update_pc, exp_pc); end
            if (mispredict !== 1'b0) begin n_bad++; $display("FAIL b2b_mis%0d got %b want 0", i, mispredict); end
        end
        while (mq.size() > 0) step(0, '0, '0, 0, 1, mq[0].p, 0);
    endtask

    task automatic test_empty_resolve();
        step(0, '0, '0, 0, 1, 1, 0);
        n_cmp += 3;
        if (update_write_enabled !== 1'b0) begin n_bad++; $display("FAIL empty_we got %b want 0", update_write_enabled); end
        if (mispredict !== 1'b0) begin n_bad++; $display("FAIL empty_mis got %b want 0", mispredict); end
        if (count !== 4'd0) begin n_bad++; $display("FAIL empty_count got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, 16'h5000 + 16'(i), 8'hC0, 1, 0, 0, 0);
        step(0, '0, '0, 0, 1, 1, 1);
        n_cmp += 5;
        if (count !== 4'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", count); end
        if (update_write_enabled !== 1'b0) begin n_bad++; $display("FAIL rstmid_we got %b want 0", update_write_enabled); end
        if (mispredict !== 1'b0) begin n_bad++; $display("FAIL rstmid_mis got %b want 0", mispredict); end
        if (push_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_push_ready got %b want 1", push_ready); end
        if (resolve_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_resolve_ready got %b want 0", resolve_ready); end
    endtask

    task automatic test_random();
        logic pv, rv, ro, rst;
        for (int i = 0; i < 400; i++) begin
            pv  = ($urandom_range(0, 99) < 60);
            rv  = ($urandom_range(0, 99) < 45);
            ro  = (mq.size() > 0) ? (mq[0].p ^ ($urandom_range(0, 99) < 12)) : 1'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            n_cmp++;
            if (push_ready !== (mq.size() < 8) || resolve_ready !== (mq.size() > 0)) begin
                n_bad++;
                $display("FAIL rnd_ready%0d got %b%b want %b%b", i, push_ready, resolve_ready,
                         mq.size() < 8, mq.size() > 0);
            end
            step(pv, 16'($urandom), 8'($urandom), 1'($urandom), rv, ro, rst);
            n_cmp++;
            if (update_write_enabled !== m_we || mispredict !== m_mis ||
                update_pc !== m_pc || update_history !== m_h ||
                update_outcome !== m_out || count !== 4'(mq.size())) begin
                n_bad++;
                $display("FAIL rnd_out%0d got we=%b mis=%b pc=%h h=%h o=%b c=%0d want we=%b mis=%b pc=%h h=%h o=%b c=%0d",
                         i, update_write_enabled, mispredict, update_pc, update_history,
                         update_outcome, count, m_we, m_mis, m_pc, m_h, m_out, mq.size());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        push_valid = 1'b0;
        push_pc = '0;
        push_history = '0;
        push_prediction = 1'b0;
        resolve_valid = 1'b0;
        resolve_outcome = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_wrap();
        test_mispredict_flush();
        test_back_to_back();
        test_empty_resolve();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
